// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the PC / next-PC fetch stage.
package pc_fetch_unit_pkg;

    // Next-PC source select
    localparam logic [1:0] PC_SEQ = 2'b00;  // PC + 4
    localparam logic [1:0] PC_BR  = 2'b01;  // PC + 4 + sign-extended word offset
    localparam logic [1:0] PC_J   = 2'b10;  // J-type target from instruction memory
    localparam logic [1:0] PC_JR  = 2'b11;  // register jump (rs value)

    // Fetch control states
    typedef enum logic [1:0] {
        S_INIT  = 2'b00,
        S_RUN   = 2'b01,
        S_HALT  = 2'b10,
        S_FAULT = 2'b11
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC candidate selection and PC4 generation.
module next_pc_mux
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pc_src,
    input  logic [15:0] immediate,
    input  logic [31:0] jump_pc,
    input  logic [31:0] reg_jump_addr,
    output logic [31:0] next_pc,
    output logic [3:0]  pc4
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;

    // Immediate is a word offset, so it is shifted left by two before adding
    assign seq_pc = pc + 32'd4;
    assign br_pc  = seq_pc + {{14{immediate[15]}}, immediate, 2'b00};
    assign pc4    = seq_pc[31:28];

    // Pick the candidate named by pc_src
    always_comb begin
        next_pc = seq_pc;
        case (pc_src)
            PC_SEQ:  next_pc = seq_pc;
            PC_BR:   next_pc = br_pc;
            PC_J:    next_pc = jump_pc;
            PC_JR:   next_pc = reg_jump_addr;
            default: next_pc = seq_pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, run/halt/fault control, fetch-address check and retired
// instruction counter for the single-cycle MIPS fetch stage.
//
// Flow control: PCWre is a stall qualifier, not a handshake. In S_RUN an
// edge with PCWre=1 (and no halt or fault) retires the current instruction
// and advances the PC; PCWre=0 holds PC and counter. There is no
// back-pressure toward the caller. The FSM state is held in `state` so
// checkers can observe it directly.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [15:0] Immediate,
    input  logic [31:0] JumpPC,
    input  logic [31:0] RegJumpAddr,
    input  logic        Halt,
    output logic [31:0] InsAddr,
    output logic [3:0]  PC4,
    output logic        InsMemRW,
    output logic [31:0] NextPC,
    output logic        Halted,
    output logic        AddrErr,
    output logic [31:0] FaultAddr,
    output logic [31:0] InstrCount
);

    // Highest word-aligned address that still lies inside the instruction memory
    localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

    state_t state;
    logic   addr_bad;

    next_pc_mux u_next_pc_mux (
        .pc            (InsAddr),
        .pc_src        (PCSrc),
        .immediate     (Immediate),
        .jump_pc       (JumpPC),
        .reg_jump_addr (RegJumpAddr),
        .next_pc       (NextPC),
        .pc4           (PC4)
    );

    // A target is rejected if misaligned or past the last word of memory
    assign addr_bad = (NextPC[1:0] != 2'b00) || (NextPC > LAST_ADDR);

    // Fetch FSM with PC, counter and sticky flags as registered outputs
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state      <= S_INIT;
            InsAddr    <= RESET_PC;
            InsMemRW   <= 1'b0;
            Halted     <= 1'b0;
            AddrErr    <= 1'b0;
            FaultAddr  <= 32'd0;
            InstrCount <= 32'd0;
        end else begin
            case (state)
                S_INIT: begin
                    // One read cycle for the first instruction; PC held
                    state    <= S_RUN;
                    InsMemRW <= 1'b1;
                end
                S_RUN: begin
                    if (Halt) begin
                        // The halt instruction itself retires
                        state      <= S_HALT;
                        Halted     <= 1'b1;
                        InsMemRW   <= 1'b0;
                        InstrCount <= InstrCount + 32'd1;
                    end else if (!PCWre) begin
                        state <= S_RUN;
                    end else if (addr_bad) begin
                        state     <= S_FAULT;
                        AddrErr   <= 1'b1;
                        FaultAddr <= NextPC;
                        InsMemRW  <= 1'b0;
                    end else begin
                        InsAddr    <= NextPC;
                        InstrCount <= InstrCount + 32'd1;
                    end
                end
                default: begin
                    // S_HALT / S_FAULT: everything frozen until reset
                    state    <= state;
                    InsMemRW <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and next-PC stage of the single-cycle MIPS CPU, directly upstream of the instruction memory.
- Holds the PC and drives the memory's InsAddr, InsMemRW and PC4 inputs.
- Selects the next PC from sequential, branch, J-type jump and register-jump sources.
- Tracks run/halt/fault state and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_BYTES, 128: instruction memory size in bytes; the highest legal fetch address is IMEM_BYTES-4.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset (sampled on the CLK rising edge).
- PCWre  input  1  PC write enable; 0 = stall, PC held.
- PCSrc  input  2  next-PC select: 00 PC+4, 01 branch, 10 jump (JumpPC), 11 register jump (RegJumpAddr).
- Immediate  input  16  branch offset in words, signed.
- JumpPC  input  32  J-type target, as assembled by the instruction memory.
- RegJumpAddr  input  32  jr target (rs value).
- Halt  input  1  decoded halt instruction.
- InsAddr  output  32  current PC; fetch address.
- PC4  output  4  bits [31:28] of PC+4.
- InsMemRW  output  1  instruction memory read enable.
- NextPC  output  32  combinational next-PC candidate.
- Halted  output  1  sticky halt flag.
- AddrErr  output  1  sticky fetch-fault flag.
- FaultAddr  output  32  rejected target address.
- InstrCount  output  32  number of retired instructions.

Behaviour:
- Reset:
  - Reset=0 at a rising edge: InsAddr=RESET_PC, state=S_INIT, InsMemRW=0, Halted=0, AddrErr=0, FaultAddr=0, InstrCount=0.
  - Reset overrides every other input, including in S_HALT and S_FAULT and mid-stall.
- Next-PC arithmetic (combinational, all modulo 2^32):
  - Seq = InsAddr+4.
  - Br = Seq + ({{14{Immediate[15]}},Immediate,2'b00}).
  - NextPC = Seq / Br / JumpPC / RegJumpAddr for PCSrc 00 / 01 / 10 / 11.
  - PC4 = Seq[31:28], always combinational from the current PC.
- State machine (S_INIT, S_RUN, S_HALT, S_FAULT):
  - S_INIT: lasts exactly one cycle, InsMemRW=1, PC held; then goes to S_RUN. This gives the memory one read cycle for the first instruction.
  - S_RUN: InsMemRW=1. Priority at each edge, highest first:
    - Halt=1: PC held; go to S_HALT; Halted=1; InstrCount+1 (the halt instruction retires).
    - PCWre=0: PC held, counter held, stay in S_RUN.
    - NextPC[1:0]!=0 or NextPC>IMEM_BYTES-4: PC held; FaultAddr=NextPC; AddrErr=1; go to S_FAULT; counter not incremented.
    - Otherwise: InsAddr<=NextPC; InstrCount+1.
  - S_HALT, S_FAULT:
    - InsMemRW=0, so the memory holds its last instruction.
    - PC, counter and flags frozen; all inputs ignored until reset.
- Latency: NextPC appears on InsAddr one edge after it is selected; no other pipelining.
- InstrCount wraps from 32'hFFFF_FFFF to 0 without a flag.
- Halt and fault in the same cycle: Halt wins; AddrErr stays 0.
- A branch or jump to the current PC (self-loop) is legal and retires every cycle.

Decomposition:
- Shared package/header holds:
  - PCSrc encodings: PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11.
  - State encodings: S_INIT, S_RUN, S_HALT, S_FAULT.
  - RESET_PC default.
- One sub-module, next_pc_mux: purely combinational Seq/Br/select logic producing NextPC and PC4.
- The PC register, FSM, fault check and counter stay in pc_fetch_unit.

Test Plan:
- Reset then 3 cycles of PCSrc=00, PCWre=1 -> InsAddr 0 (S_INIT), 0, 4, 8; InsMemRW 0,1,1,1; InstrCount=2.
- Branch: InsAddr=8, PCSrc=01, Immediate=16'hFFFE -> next InsAddr=4; Immediate=16'h0003 from 8 -> 24.
- Jump / register jump: PCSrc=10 with JumpPC=32'h0000_0040 -> InsAddr=0x40. PCSrc=11 with RegJumpAddr=32'h0000_0042 -> AddrErr=1, FaultAddr=0x42, InsAddr unchanged, InsMemRW=0.
- Stall, then halt:
  - PCWre=0 for 2 cycles at InsAddr=12 -> InsAddr stays 12 and InstrCount is unchanged.
  - Then Halt=1 -> Halted=1, InstrCount+1, InsMemRW=0; later PCSrc/PCWre changes have no effect.
- Bounds and simultaneous events:
  - From InsAddr=124 with PCSrc=00 (target 128) -> fault.
  - Halt=1 together with an illegal target -> Halted=1, AddrErr=0.
- Reset mid-operation: Reset=0 for one edge while in S_FAULT or S_RUN at 0x40 -> InsAddr=0, flags cleared, S_INIT entered, InstrCount=0.
